// File: rtl/hash_uut_pkg.sv
// Shared types and config-field layout for the hash UUT adapter.
// The word-count clamp lives here so that the FSM and any checker agree on it.
package hash_uut_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam int NWORDS     = 16;
  localparam int CFG_NW_LSB = 0;
  localparam int CFG_NW_W   = 5;
  localparam int CFG_TO_LSB = 16;
  localparam int CFG_TO_W   = 16;

  localparam logic [CFG_NW_W-1:0] NWORDS_F = CFG_NW_W'(NWORDS);

  // Zero or over-range word counts mean a full block.
  function automatic logic [CFG_NW_W-1:0] eff_nwords(input logic [CFG_NW_W-1:0] f);
    logic [CFG_NW_W-1:0] n;
    if (f == 5'd0 || f > NWORDS_F) begin
      n = NWORDS_F;
    end else begin
      n = f;
    end
    return n;
  endfunction

endpackage

// File: rtl/hash_uut_adapter_word_serializer.sv
// Parallel-load shift register that presents a block MSW-first over a
// valid/ready/last word handshake toward the hash core.
module word_serializer
  import hash_uut_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 512,
  parameter int CNT_W   = CFG_NW_W
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [CNT_W-1:0]   nwords_i,
  input  logic               ready_i,
  output logic [WORD_W-1:0]  word_o,
  output logic               valid_o,
  output logic               last_o,
  output logic               xfer_last_o
);

  logic [BLOCK_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   nw_q, nw_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               xfer_s;

  assign xfer_s      = valid_q & ready_i;
  assign xfer_last_o = xfer_s & last_q;
  assign word_o      = sreg_q[BLOCK_W-1 -: WORD_W];
  assign valid_o     = valid_q;
  assign last_o      = last_q;

  // Load, shift and last-word tracking; last is precomputed so it is a flop output.
  always_comb begin
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    nw_d    = nw_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_i) begin
      sreg_d  = block_i;
      idx_d   = '0;
      nw_d    = nwords_i;
      valid_d = 1'b1;
      last_d  = (nwords_i == CNT_W'(1));
    end else if (xfer_s) begin
      sreg_d = sreg_q << WORD_W;
      if (last_q) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        idx_d  = idx_q + CNT_W'(1);
        last_d = ((idx_q + CNT_W'(2)) == nw_q);
      end
    end else begin
      sreg_d = sreg_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sreg_q  <= '0;
      idx_q   <= '0;
      nw_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      nw_q    <= nw_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/hash_uut_adapter.sv
// Adapter between the autotest controller's flat UUT interface and a hash core:
// latches block/config, streams words, captures the digest, reports timeout and latency.
module hash_uut_adapter
  import hash_uut_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int BLOCK_W  = 512,
  parameter int CFG_W    = 32,
  parameter int DIGEST_W = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rst_uut,
  input  logic [BLOCK_W-1:0]  block_in,
  input  logic [CFG_W-1:0]    cfg_in,
  output logic [DIGEST_W-1:0] result_out,
  output logic                end_uut,
  output logic                err_uut,
  output logic [31:0]         cycle_count,
  output logic                hash_rst,
  output logic [WORD_W-1:0]   msg_word,
  output logic                msg_valid,
  output logic                msg_last,
  input  logic                msg_ready,
  input  logic [DIGEST_W-1:0] digest_in,
  input  logic                digest_valid
);

  state_e                state_q, state_d;
  logic [CFG_TO_W-1:0]   timeout_q, timeout_d;
  logic [31:0]           count_q, count_d;
  logic [DIGEST_W-1:0]   result_q, result_d;
  logic                  end_q, end_d;
  logic                  err_q, err_d;
  logic                  hash_rst_q, hash_rst_d;
  logic                  rst_any;
  logic                  ser_load, ser_clr;
  logic                  xfer_last;
  logic                  capture, to_hit;
  logic [31:0]           count_inc;
  logic [CFG_NW_W-1:0]   nwords;
  logic                  unused_cfg;

  assign rst_any    = rst | rst_uut;
  assign nwords     = eff_nwords(cfg_in[CFG_NW_LSB +: CFG_NW_W]);
  assign unused_cfg = ^{cfg_in[CFG_W-1:CFG_TO_LSB+CFG_TO_W], cfg_in[CFG_TO_LSB-1:CFG_NW_LSB+CFG_NW_W]};
  assign count_inc  = (count_q == 32'hFFFF_FFFF) ? count_q : (count_q + 32'd1);
  // A digest during SEND is a protocol violation and is never captured.
  assign capture    = (state_q == S_WAIT) && digest_valid;
  assign to_hit     = ((state_q == S_SEND) || (state_q == S_WAIT)) && (timeout_q != '0)
                      && (count_q == {{(32-CFG_TO_W){1'b0}}, timeout_q}) && !capture;

  word_serializer #(
    .WORD_W (WORD_W),
    .BLOCK_W(BLOCK_W),
    .CNT_W  (CFG_NW_W)
  ) u_ser (
    .clk_i      (clk),
    .clr_i      (rst_any | ser_clr),
    .load_i     (ser_load),
    .block_i    (block_in),
    .nwords_i   (nwords),
    .ready_i    (msg_ready),
    .word_o     (msg_word),
    .valid_o    (msg_valid),
    .last_o     (msg_last),
    .xfer_last_o(xfer_last)
  );

  // Run sequencing, latency counter and result/status next-state.
  always_comb begin
    state_d    = state_q;
    timeout_d  = timeout_q;
    count_d    = count_q;
    result_d   = result_q;
    end_d      = end_q;
    err_d      = err_q;
    hash_rst_d = hash_rst_q;
    ser_load   = 1'b0;
    ser_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        hash_rst_d = 1'b0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        timeout_d = cfg_in[CFG_TO_LSB +: CFG_TO_W];
        ser_load  = 1'b1;
        count_d   = 32'd0;
        state_d   = S_SEND;
      end
      S_SEND, S_WAIT: begin
        // Timeout freezes the count at the limit; a capture counts its own cycle.
        if (to_hit) begin
          ser_clr  = 1'b1;
          result_d = '0;
          end_d    = 1'b1;
          err_d    = 1'b1;
          state_d  = S_ERR;
        end else begin
          count_d = count_inc;
          if (capture) begin
            result_d = digest_in;
            end_d    = 1'b1;
            err_d    = 1'b0;
            state_d  = S_DONE;
          end else if ((state_q == S_SEND) && xfer_last) begin
            state_d = S_WAIT;
          end else begin
            state_d = state_q;
          end
        end
      end
      S_DONE, S_ERR: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      state_q    <= S_IDLE;
      timeout_q  <= '0;
      count_q    <= 32'd0;
      result_q   <= '0;
      end_q      <= 1'b0;
      err_q      <= 1'b0;
      hash_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timeout_q  <= timeout_d;
      count_q    <= count_d;
      result_q   <= result_d;
      end_q      <= end_d;
      err_q      <= err_d;
      hash_rst_q <= hash_rst_d;
    end
  end

  assign result_out  = result_q;
  assign end_uut     = end_q;
  assign err_uut     = err_q;
  assign cycle_count = count_q;
  assign hash_rst    = hash_rst_q;

endmodule

// File: doc/hash_uut_adapter.md
Name: hash_uut_adapter

Overview:
- Sits directly downstream of the autotest controller, between its flat UUT interface and the hash core under test.
- Latches the parallel message block and config word presented by the controller, streams the block into the hash core over a valid/ready word interface, and captures the digest.
- Reports completion and timeout errors back to the controller, along with a latency count in cycles.

Parameters:
- WORD_W, 32, message word width toward the hash core.
- BLOCK_W, 512, width of the block input; NWORDS = BLOCK_W/WORD_W = 16.
- CFG_W, 32, width of the config input.
- DIGEST_W, 256, digest width, and width of the result output.

Ports:
- clk  in  1  system clock
- rst  in  1  global reset, synchronous, active-high
- rst_uut  in  1  UUT reset from the controller, synchronous, active-high
- block_in  in  BLOCK_W  message block; word 0 = bits [BLOCK_W-1 -: WORD_W] (MSW first)
- cfg_in  in  CFG_W  [4:0] word count (0 means NWORDS); [31:16] timeout in cycles (0 means disabled)
- result_out  out  DIGEST_W  captured digest
- end_uut  out  1  run finished (success or error)
- err_uut  out  1  run ended by timeout
- cycle_count  out  32  cycles from the first SEND cycle to digest capture or timeout
- hash_rst  out  1  reset to the hash core, equal to rst | rst_uut (registered)
- msg_word  out  WORD_W  current message word
- msg_valid  out  1  msg_word is valid
- msg_last  out  1  current word is the final word
- msg_ready  in  1  hash core accepts the word
- digest_in  in  DIGEST_W  digest from the hash core
- digest_valid  in  1  digest_in is valid; single-cycle pulse

Behaviour:
- Reset: when rst=1 or rst_uut=1 at a clock edge, the following hold from the next cycle:
  - state=IDLE
  - result_out=0, end_uut=0, err_uut=0, cycle_count=0
  - msg_valid=0, msg_last=0, msg_word=0
  - hash_rst=1
- rst_uut asserted mid-run aborts immediately to IDLE, with no partial result retained.
- IDLE: with both resets low, go to LOAD on the next cycle. hash_rst=0 from that cycle.
- LOAD (1 cycle):
  - Register block_in into shift register sreg and cfg_in into cfg_q.
  - nwords = (cfg[4:0]==0 || cfg[4:0]>NWORDS) ? NWORDS : cfg[4:0].
  - Word index idx=0; go to SEND.
- SEND:
  - msg_valid=1, msg_word = top word of sreg, msg_last = (idx==nwords-1).
  - A transfer occurs when msg_valid & msg_ready. On transfer: sreg shifts left by WORD_W and idx increments.
  - Hold msg_word and msg_last stable while ready is low.
  - After the transfer with msg_last=1, go to WAIT; msg_valid deasserts the following cycle.
- WAIT: msg_valid=0. On digest_valid=1: result_out<=digest_in, go to DONE.
- digest_valid arriving during SEND is ignored (protocol violation, not captured).
- DONE: end_uut=1, err_uut=0, result_out and cycle_count held. Leave only via rst/rst_uut.
- Timeout:
  - cycle_count starts at 0 on entering SEND and increments every cycle in SEND/WAIT, saturating at 32'hFFFF_FFFF.
  - If timeout != 0 and cycle_count == timeout while in SEND or WAIT with no capture that cycle, go to ERR.
  - If digest_valid and the timeout condition occur in the same cycle, the digest wins and the FSM goes to DONE.
- ERR: end_uut=1, err_uut=1, result_out=0, msg_valid=0. Leave only via reset.
- Outputs are registered; end_uut is visible 1 cycle after the capture/timeout edge.
- States: IDLE, LOAD, SEND, WAIT, DONE, ERR.

Decomposition:
- Package hash_uut_pkg holds:
  - the state enum typedef;
  - constants NWORDS, CFG_NW_LSB=0, CFG_NW_W=5, CFG_TO_LSB=16, CFG_TO_W=16.
- One sub-module: word_serializer (parallel load plus shift-out with the valid/ready/last handshake). The FSM, timeout and counter logic live in the top.

Test Plan:
- Full block: block_in = 512'h00010203…3C3D3E3F pattern, cfg=0, msg_ready=1, digest_valid 5 cycles after last.
  - Expect 16 words, first 32'h00010203, msg_last on word 16.
  - Expect result_out=digest_in, end_uut=1, err_uut=0, cycle_count=21.
- Backpressure: msg_ready toggles 1,0,0,1 repeating, cfg nwords=4.
  - Each word is held stable while ready=0.
  - Exactly 4 transfers; msg_last only on the 4th.
- Timeout: cfg=32'h000A_0010, digest_valid never asserted.
  - ERR at cycle_count=10: end_uut=1, err_uut=1, result_out=0.
- Tie: timeout=20, digest_valid asserted exactly on the cycle where cycle_count==20.
  - DONE with the digest captured, err_uut=0.
- Abort: rst_uut asserted during SEND at word 7.
  - Next cycle: IDLE, msg_valid=0, hash_rst=1, end_uut=0.
  - After release, a rerun sends word 0 again.
- Word count clamp: cfg nwords=20.
  - Exactly 16 words sent; msg_last on word 16.
